ip_daec_encoder: RTL and testbench
==================================

IP_DAEC_ENCODER -- requirements
Module: ip_daec_encoder

Interface
REQ-001 Parameter CNT_W, default 16, is the width of the encoded-word counter.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  data_in is valid this cycle.
REQ-005 in_ready  output  1  block accepts data_in this cycle.
REQ-006 data_in  input  64  payload; byte i = data_in[8i+7:8i], i = 0..7.
REQ-007 out_valid  output  1  codeword_out is valid this cycle.
REQ-008 out_ready  input  1  downstream accepts codeword_out this cycle.
REQ-009 codeword_out  output  80  encoded word for the IP-DAEC decoder.
REQ-010 cnt_clr  input  1  synchronous clear of enc_count.
REQ-011 enc_count  output  CNT_W  number of codewords delivered; saturating.

Function
REQ-012 Codeword layout SHALL be: [63:0] = data, [71:64] = P0, [79:72] = P1; there are 10 symbols of 8 bits, numbered 0..9 from LSB.
REQ-013 P0 SHALL equal the XOR of data bytes 0..7.
REQ-014 P1 SHALL equal the XOR over i of (byte i * alpha^i) in GF(2^8), with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D) and alpha = 0x02.
REQ-015 Pipeline SHALL have two register stages: S1 holds the data plus the eight GF products; S2 holds the final codeword.
REQ-016 Latency SHALL be 2 cycles from an accepted input (in_valid & in_ready) to out_valid, provided no stall occurs.
REQ-017 Throughput SHALL be one word per cycle while out_ready = 1.
REQ-018 An input transfer occurs iff in_valid & in_ready; an output transfer occurs iff out_valid & out_ready.
REQ-019 S2 SHALL load when S1 is valid and (S2 is empty or out_ready = 1).
REQ-020 S1 SHALL load when S1 is empty or S1 moves to S2 in the same cycle.
REQ-021 in_ready SHALL equal (S1 empty) OR (S1 moves this cycle); it is combinational and SHALL NOT depend on in_valid.
REQ-022 While out_valid = 1 and out_ready = 0, codeword_out and out_valid SHALL hold stable.
REQ-023 A full pipeline under a stall SHALL hold exactly 2 words, with none lost or duplicated; in_ready = 0 until out_ready returns.
REQ-024 Word order SHALL be preserved.
REQ-025 data_in SHALL be ignored when in_valid = 0 or in_ready = 0.
REQ-026 enc_count SHALL increment by 1 on each output transfer and saturate at 2^CNT_W-1.
REQ-027 When cnt_clr and an output transfer occur in the same cycle, cnt_clr SHALL win and enc_count = 0.
REQ-028 cnt_clr SHALL NOT affect pipeline contents.
REQ-029 The block SHALL contain no combinational path from data_in to codeword_out.

Reset
REQ-030 While rst_n = 0: out_valid = 0, codeword_out = 0, enc_count = 0, S1/S2 valid flags = 0, and in_ready = 1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight words immediately (asynchronously).
REQ-032 First acceptance after reset SHALL occur on the first rising edge with rst_n = 1 and in_valid = 1.

Verification
REQ-033 data_in = 0, single word, out_ready = 1 -> codeword_out = 80'h0, out_valid high exactly 2 cycles after acceptance, enc_count = 1.
REQ-034 Single-byte patterns -> codeword_out[79:64] as follows:
  - byte0 = 0x01 -> 16'h0101
  - byte1 = 0x01 -> 16'h0201
  - byte7 = 0x01 -> 16'h8001
  - byte7 = 0x02 -> 16'h1D02
REQ-035 Streaming 8 back-to-back words with out_ready held 0 from cycle 3 -> in_ready drops after 2 words are held; release out_ready -> all 8 codewords emerge in order, 1/cycle, no loss.
REQ-036 Loopback: random data_in -> codeword_out fed to IP-DAEC decoder -> decode_result clean, data_out = data_in.
REQ-037 Assert rst_n low with 2 words in flight -> out_valid = 0 immediately, enc_count = 0; no stale word emerges after release.
REQ-038 CNT_W = 4, 20 transfers -> enc_count saturates at 15; cnt_clr coincident with a transfer -> enc_count = 0.

Source files
------------

// File: rtl/ip_daec_encoder.sv
// rtl/ip_daec_encoder.sv - IP-DAEC 64-bit data to 80-bit codeword encoder, two-stage pipeline
// Parity symbols: P0 = XOR of data bytes, P1 = XOR of byte_i * alpha^i over GF(2^8)/0x11D.
module ip_daec_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [79:0]      codeword_out,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] enc_count
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
  endfunction

  // Multiply by alpha^n through n successive xtime steps (n is a constant per byte lane).
  function automatic logic [7:0] mul_alpha_pow(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int k = 0; k < 8; k++) begin
      if (k < n) r = xtime(r);
    end
    mul_alpha_pow = r;
  endfunction

  logic [7:0]  prod_in [8];
  logic        s1_valid;
  logic [63:0] s1_data;
  logic [7:0]  s1_prod [8];
  logic        s2_valid;
  logic [79:0] s2_code;
  logic        s2_load;
  logic        in_fire;
  logic        out_fire;
  logic [7:0]  p0;
  logic [7:0]  p1;

  for (genvar i = 0; i < 8; i++) begin : g_prod
    assign prod_in[i] = mul_alpha_pow(data_in[8*i +: 8], i);
  end

  assign s2_load  = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_valid & out_ready;

  always_comb begin
    p0 = 8'h00;
    p1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      p0 = p0 ^ s1_data[8*i +: 8];
      p1 = p1 ^ s1_prod[i];
    end
  end

  // Stage 1: data plus the eight lane products; data only captured on a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= 64'h0;
      for (int i = 0; i < 8; i++) s1_prod[i] <= 8'h00;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_data <= data_in;
        for (int i = 0; i < 8; i++) s1_prod[i] <= prod_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_code  <= 80'h0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_code  <= {p1, p0, s1_data};
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid    = s2_valid;
  assign codeword_out = s2_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
    end else if (cnt_clr) begin
      enc_count <= '0;
    end else if (out_fire && (enc_count != {CNT_W{1'b1}})) begin
      enc_count <= enc_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ip_daec_encoder.sv
// tb/tb_ip_daec_encoder.sv - directed self-checking bench for ip_daec_encoder
module tb_ip_daec_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] codeword_out;
  logic        cnt_clr;
  logic [3:0]  enc_count;

  int total = 0;
  int bad   = 0;

  ip_daec_encoder #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .codeword_out(codeword_out),
    .cnt_clr     (cnt_clr),
    .enc_count   (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply, reduction by 0x11D.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
    end
    return acc;
  endfunction

  function automatic logic [79:0] model(input logic [63:0] d);
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] apow;
    p0 = 8'h00;
    p1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      apow = 8'h01 << i;
      p0 = p0 ^ d[8*i +: 8];
      p1 = p1 ^ gmul(d[8*i +: 8], apow);
    end
    return {p1, p0, d};
  endfunction

  task automatic send_word(input logic [63:0] d, output logic [79:0] cw, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = d;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    cw = codeword_out;
    @(negedge clk);
  endtask

  logic [79:0] cw;
  int          lat;
  logic [63:0] w [8];
  logic [63:0] rnd;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 64'h0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_codeword", codeword_out, 80'h0);
    check("rst_enc_count", enc_count, 4'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    send_word(64'h0, cw, lat);
    check("zero_codeword", cw, 80'h0);
    check("zero_latency", lat, 2);
    check("zero_count", enc_count, 4'd1);
    check("zero_drained", out_valid, 1'b0);

    send_word(64'h0000_0000_0000_0001, cw, lat);
    check("byte0_parity", cw[79:64], 16'h0101);
    check("byte0_data", cw[63:0], 64'h0000_0000_0000_0001);
    send_word(64'h0000_0000_0000_0100, cw, lat);
    check("byte1_parity", cw[79:64], 16'h0201);
    send_word(64'h0100_0000_0000_0000, cw, lat);
    check("byte7_01_parity", cw[79:64], 16'h8001);
    send_word(64'h0200_0000_0000_0000, cw, lat);
    check("byte7_02_parity", cw[79:64], 16'h1D02);
    check("count_after_bytes", enc_count, 4'd5);

    for (int n = 0; n < 3; n++) begin
      rnd = {$urandom, $urandom};
      send_word(rnd, cw, lat);
      check("random_codeword", cw, model(rnd));
      check("random_latency", lat, 2);
    end
    check("count_after_random", enc_count, 4'd8);

    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("count_cleared", enc_count, 4'd0);

    // Stall: out_ready low from cycle 3 to 9, eight words offered back-to-back.
    for (int i = 0; i < 8; i++) w[i] = {$urandom, $urandom};
    begin
      int acc;
      int outn;
      int last_out;
      acc = 0;
      outn = 0;
      last_out = -1;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        out_ready = (cyc < 3) || (cyc >= 10);
        in_valid  = (acc < 8);
        data_in   = (acc < 8) ? w[acc] : 64'h0;
        #1;
        if (cyc == 9) begin
          check("stall_in_ready", in_ready, 1'b0);
          check("stall_accepted", acc, 3);
          check("stall_emitted", outn, 1);
        end
        if (cyc >= 4 && cyc <= 9) begin
          check("stall_hold_valid", out_valid, 1'b1);
          check("stall_hold_word", codeword_out, model(w[1]));
        end
        if (out_valid && out_ready) begin
          if (outn < 8) check("stream_order", codeword_out, model(w[outn]));
          outn++;
          last_out = cyc;
        end
        if (in_valid && in_ready) acc++;
      end
      in_valid = 1'b0;
      check("stream_out_total", outn, 8);
      check("stream_in_total", acc, 8);
      check("stream_last_cycle", last_out, 16);
      check("stream_count", enc_count, 4'd8);
    end

    // Asynchronous reset with two words held in the pipeline.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = {$urandom, $urandom};
    @(negedge clk);
    data_in = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1'b1);
    check("pre_reset_blocked", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_codeword", codeword_out, 80'h0);
    check("async_rst_count", enc_count, 4'd0);
    check("async_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_stale_word", out_valid, 1'b0);
    end

    // Saturation at 15 with CNT_W=4, then a clear coincident with a transfer.
    begin
      int n;
      int guard;
      n = 0;
      guard = 0;
      in_valid = 1'b1;
      while (n < 20 && guard < 60) begin
        @(negedge clk);
        data_in = {$urandom, $urandom};
        #1;
        if (out_valid && out_ready) n++;
        guard++;
      end
      check("sat_transfers", n, 20);
      @(negedge clk);
      check("sat_count", enc_count, 4'd15);
      check("sat_streaming", out_valid, 1'b1);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      check("clr_wins", enc_count, 4'd0);
      check("clr_keeps_pipe", out_valid, 1'b1);
      @(negedge clk);
      check("count_after_clr", enc_count, 4'd1);
      in_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
